fetch_if_id_stage: RTL

//  Instruction-fetch stage plus IF/ID pipeline register. Owns the PC and presents it to the

---
 rtl/fetch_if_id_stage.sv | 111 +++++++++++
 1 files changed

// File: rtl/fetch_if_id_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction memory and
// latches the fetched word into IF/ID. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pcstop_i,
    input  logic        idif_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic [31:0] imem_instr_i,
    output logic [31:0] imem_addr_o,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc4_o,
    output logic        if_id_valid_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        redirect_apply;

    assign pc_plus4       = pc_q + 32'd4;
    // A stalled PC swallows the redirect; the hazard unit re-presents it later.
    assign redirect_apply = redirect_i & ~pcstop_i;

    always_comb begin
        pc_d = pc_q;
        if (!pcstop_i) begin
            if (redirect_i) pc_d = {redirect_pc_i[31:2], 2'b00};
            else            pc_d = pc_plus4;
        end
    end

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (idif_i) begin
            if (redirect_apply) begin
                instr_d = NOP_WORD;
                pc4_d   = 32'd0;
                valid_d = 1'b0;
            end else begin
                instr_d = imem_instr_i;
                pc4_d   = pc_plus4;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pcstop_i && (stall_cnt_q != 32'hFFFF_FFFF))       stall_cnt_d = stall_cnt_q + 32'd1;
        if (redirect_apply && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = 32'd0;
    assign flush_cnt_o = 32'd0;
`endif

    assign imem_addr_o   = pc_q;
    assign if_id_instr_o = instr_q;
    assign if_id_pc4_o   = pc4_q;
    assign if_id_valid_o = valid_q;

`ifndef SYNTHESIS
    // Advancing the PC while IF/ID holds would silently drop an instruction.
    a_no_pc_adv_with_ifid_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        !(!pcstop_i && !idif_i));
`endif

endmodule
